// File: rtl/tpu_commit_ctrl_pkg.sv
// TPU commit controller shared types.
// Order-FIFO sizing defaults and commit FSM encoding.
package tpu_commit_ctrl_pkg;

  localparam int DEPTH_BUFF_DFLT = 16;
  localparam int WIDTH_BUFF_DFLT = $clog2(DEPTH_BUFF_DFLT);

  typedef logic [WIDTH_BUFF_DFLT-1:0] issue_no_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } commit_state_t;

endpackage

// File: rtl/tpu_commit_ctrl_ring.sv
// Order-FIFO pointer and occupancy tracking for the commit controller.
// Count, full and empty are registered together so they never disagree.
module tpu_commit_ctrl_ring #(
  parameter  int NUM_ENTRY = 16,
  localparam int W         = $clog2(NUM_ENTRY)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  output logic [W-1:0] wr_ptr,
  output logic [W-1:0] rd_ptr,
  output logic [W:0]   num,
  output logic         full,
  output logic         empty
);

  localparam logic [W-1:0] PTR_ONE = W'(1);
  localparam logic [W:0]   CNT_ONE = (W+1)'(1);
  localparam logic [W:0]   CNT_MAX = (W+1)'(NUM_ENTRY);

  logic [W:0] num_d;

  always_comb begin
    num_d = num;
    unique case ({push, pop})
      2'b10:   num_d = num + CNT_ONE;
      2'b01:   num_d = num - CNT_ONE;
      default: num_d = num;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      num    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      num   <= num_d;
      full  <= (num_d == CNT_MAX);
      empty <= (num_d == '0);
    end
  end

endmodule

// File: rtl/tpu_commit_ctrl.sv
// In-order commit controller: tracks issue order, collects lane
// completions and retires one instruction per cycle back to the hazard table.
module tpu_commit_ctrl
  import tpu_commit_ctrl_pkg::*;
#(
  parameter  int DEPTH_BUFF = DEPTH_BUFF_DFLT,
  localparam int WIDTH_BUFF = $clog2(DEPTH_BUFF)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  I_Issue_Req,
  input  logic [WIDTH_BUFF-1:0] I_Issue_No,
  input  logic                  I_Done_S_Req,
  input  logic [WIDTH_BUFF-1:0] I_Done_S_No,
  input  logic                  I_Done_V_Req,
  input  logic [WIDTH_BUFF-1:0] I_Done_V_No,
  input  logic                  I_Flush,
  output logic                  O_Commit_Req,
  output logic [WIDTH_BUFF-1:0] O_Commit_No,
  output logic                  O_Full,
  output logic                  O_Empty,
  output logic                  O_Busy,
  output logic [WIDTH_BUFF:0]   O_Num,
  output logic                  O_Err
);

  localparam int W = WIDTH_BUFF;
  localparam logic [W:0] CNT_ONE = (W+1)'(1);

  logic [W-1:0]          wr_ptr;
  logic [W-1:0]          rd_ptr;
  logic [W:0]            num;
  logic                  full;
  logic                  empty;
  logic [W-1:0]          order_q [DEPTH_BUFF];
  logic [W-1:0]          head;
  logic [DEPTH_BUFF-1:0] done_q;
  logic [DEPTH_BUFF-1:0] done_d;
  logic [DEPTH_BUFF-1:0] valid_q;
  logic [DEPTH_BUFF-1:0] valid_d;
  commit_state_t         state_q;
  commit_state_t         state_d;
  logic                  push;
  logic                  pop;
  logic                  busy;
  logic                  ready;
  logic                  last;
  logic                  iss_err;
  logic                  done_err;
  logic                  commit_req_q;
  logic [W-1:0]          commit_no_q;
  logic                  err_q;

  tpu_commit_ctrl_ring #(
    .NUM_ENTRY (DEPTH_BUFF)
  ) u_ring (
    .clock  (clock),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .num    (num),
    .full   (full),
    .empty  (empty)
  );

  assign head  = order_q[rd_ptr];
  assign ready = !empty && done_q[head];
  assign last  = (num == CNT_ONE);

  assign push    = I_Issue_Req && !full && !busy;
  assign iss_err = I_Issue_Req && (full || busy);

  // A completion only counts for a number that is currently outstanding
  assign done_err = (I_Done_S_Req && !valid_q[I_Done_S_No]) ||
                    (I_Done_V_Req && !valid_q[I_Done_V_No]);

  always_ff @(posedge clock) begin
    if (!reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (push)
          state_d = RUN;
      RUN:
        if (pop && !push && last)
          state_d = IDLE;
        else if (I_Flush)
          state_d = FLUSH;
      FLUSH:
        if (empty || last)
          state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    pop  = 1'b0;
    busy = 1'b0;
    unique case (1'b1)
      (state_q == RUN):   pop = ready;
      (state_q == FLUSH): begin
        pop  = !empty;
        busy = 1'b1;
      end
      default: begin
        pop  = 1'b0;
        busy = 1'b0;
      end
    endcase
  end

  // Clearing the popped slot wins over a late done; a re-issue wins over the clear
  always_comb begin
    done_d  = done_q;
    valid_d = valid_q;
    if (I_Done_S_Req && valid_q[I_Done_S_No])
      done_d[I_Done_S_No] = 1'b1;
    if (I_Done_V_Req && valid_q[I_Done_V_No])
      done_d[I_Done_V_No] = 1'b1;
    if (pop) begin
      done_d[head]  = 1'b0;
      valid_d[head] = 1'b0;
    end
    if (push)
      valid_d[I_Issue_No] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      done_q       <= '0;
      valid_q      <= '0;
      commit_req_q <= 1'b0;
      commit_no_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      done_q       <= done_d;
      valid_q      <= valid_d;
      commit_req_q <= pop;
      if (pop)
        commit_no_q <= head;
      err_q <= err_q || iss_err || done_err;
    end
  end

  always_ff @(posedge clock) begin
    if (push)
      order_q[wr_ptr] <= I_Issue_No;
  end

  assign O_Commit_Req = commit_req_q;
  assign O_Commit_No  = commit_no_q;
  assign O_Full       = full;
  assign O_Empty      = empty;
  assign O_Busy       = busy;
  assign O_Num        = num;
  assign O_Err        = err_q;

endmodule

// File: tb/tb_tpu_commit_ctrl.sv
// Self-checking bench for tpu_commit_ctrl.
// Directed vector table plus hand-written multi-cycle sequences.
module tb_tpu_commit_ctrl;
  import tpu_commit_ctrl_pkg::*;

  localparam int D = 16;
  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         I_Issue_Req;
  logic [W-1:0] I_Issue_No;
  logic         I_Done_S_Req;
  logic [W-1:0] I_Done_S_No;
  logic         I_Done_V_Req;
  logic [W-1:0] I_Done_V_No;
  logic         I_Flush;
  logic         O_Commit_Req;
  logic [W-1:0] O_Commit_No;
  logic         O_Full;
  logic         O_Empty;
  logic         O_Busy;
  logic [W:0]   O_Num;
  logic         O_Err;

  tpu_commit_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .I_Issue_Req  (I_Issue_Req),
    .I_Issue_No   (I_Issue_No),
    .I_Done_S_Req (I_Done_S_Req),
    .I_Done_S_No  (I_Done_S_No),
    .I_Done_V_Req (I_Done_V_Req),
    .I_Done_V_No  (I_Done_V_No),
    .I_Flush      (I_Flush),
    .O_Commit_Req (O_Commit_Req),
    .O_Commit_No  (O_Commit_No),
    .O_Full       (O_Full),
    .O_Empty      (O_Empty),
    .O_Busy       (O_Busy),
    .O_Num        (O_Num),
    .O_Err        (O_Err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int iss; int ino;
    int ds;  int dsn;
    int dv;  int dvn;
    int fl;
    int e_req; int e_no; int e_num; int e_emp; int e_err;
  } vec_t;

  vec_t tv[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string t, input int req, input int no,
                           input int num, input int full, input int emp,
                           input int busy, input int err);
    check({t, ".req"}, int'(O_Commit_Req), req);
    if (req != 0)
      check({t, ".no"}, int'(O_Commit_No), no);
    check({t, ".num"}, int'(O_Num), num);
    check({t, ".full"}, int'(O_Full), full);
    check({t, ".empty"}, int'(O_Empty), emp);
    check({t, ".busy"}, int'(O_Busy), busy);
    check({t, ".err"}, int'(O_Err), err);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    I_Issue_Req  = 1'b0;
    I_Issue_No   = '0;
    I_Done_S_Req = 1'b0;
    I_Done_S_No  = '0;
    I_Done_V_Req = 1'b0;
    I_Done_V_No  = '0;
    I_Flush      = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic issue(input int n);
    I_Issue_Req = 1'b1;
    I_Issue_No  = W'(n);
    tick();
    idle();
  endtask

  initial begin
    int q[$];
    int pend;

    // In-order completion; final done reported on both lanes at once
    tv.push_back('{1,3, 0,0, 0,0, 0,  0,0,1,0,0});
    tv.push_back('{1,7, 0,0, 0,0, 0,  0,0,2,0,0});
    tv.push_back('{1,1, 0,0, 0,0, 0,  0,0,3,0,0});
    tv.push_back('{0,0, 1,3, 0,0, 0,  0,0,3,0,0});
    tv.push_back('{0,0, 1,7, 0,0, 0,  1,3,2,0,0});
    tv.push_back('{0,0, 1,1, 1,1, 0,  1,7,1,0,0});
    tv.push_back('{0,0, 0,0, 0,0, 0,  1,1,0,1,0});
    tv.push_back('{0,0, 0,0, 0,0, 0,  0,0,0,1,0});
    // Out-of-order completion
    tv.push_back('{1,2, 0,0, 0,0, 0,  0,0,1,0,0});
    tv.push_back('{1,5, 0,0, 0,0, 0,  0,0,2,0,0});
    tv.push_back('{1,9, 0,0, 0,0, 0,  0,0,3,0,0});
    tv.push_back('{0,0, 1,9, 0,0, 0,  0,0,3,0,0});
    tv.push_back('{0,0, 1,5, 0,0, 0,  0,0,3,0,0});
    tv.push_back('{0,0, 1,2, 1,9, 0,  0,0,3,0,0});
    tv.push_back('{0,0, 0,0, 0,0, 0,  1,2,2,0,0});
    tv.push_back('{0,0, 0,0, 0,0, 0,  1,5,1,0,0});
    tv.push_back('{0,0, 0,0, 0,0, 0,  1,9,0,1,0});
    tv.push_back('{0,0, 0,0, 0,0, 0,  0,0,0,1,0});
    // Flush while idle has no effect
    tv.push_back('{0,0, 0,0, 0,0, 1,  0,0,0,1,0});
    tv.push_back('{0,0, 0,0, 0,0, 0,  0,0,0,1,0});

    // Reset with random inputs
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      I_Issue_Req  = 1'($urandom);
      I_Issue_No   = W'($urandom);
      I_Done_S_Req = 1'($urandom);
      I_Done_S_No  = W'($urandom);
      I_Done_V_Req = 1'($urandom);
      I_Done_V_No  = W'($urandom);
      I_Flush      = 1'($urandom);
      tick();
    end
    check("rst.no", int'(O_Commit_No), 0);
    check_out("rst", 0, 0, 0, 0, 1, 0, 0);
    idle();
    reset = 1'b1;

    foreach (tv[i]) begin
      I_Issue_Req  = (tv[i].iss != 0);
      I_Issue_No   = W'(tv[i].ino);
      I_Done_S_Req = (tv[i].ds != 0);
      I_Done_S_No  = W'(tv[i].dsn);
      I_Done_V_Req = (tv[i].dv != 0);
      I_Done_V_No  = W'(tv[i].dvn);
      I_Flush      = (tv[i].fl != 0);
      tick();
      check_out($sformatf("vec%0d", i), tv[i].e_req, tv[i].e_no,
                tv[i].e_num, 0, tv[i].e_emp, 0, tv[i].e_err);
    end
    idle();

    // Fill to capacity, overflow, then wrap the pointers
    do_reset();
    for (int i = 0; i < D; i++)
      issue(i);
    check_out("full", 0, 0, 16, 1, 0, 0, 0);
    issue(0);
    check_out("ovf", 0, 0, 16, 1, 0, 0, 1);
    for (int i = 0; i < D; i++)
      q.push_back(i);
    pend = -1;
    for (int k = 0; k < 40; k++) begin
      I_Done_S_Req = 1'b1;
      I_Done_S_No  = W'(q[0]);
      if (pend >= 0) begin
        I_Issue_Req = 1'b1;
        I_Issue_No  = W'(pend);
        q.push_back(pend);
      end
      tick();
      idle();
      check($sformatf("wrapA%0d.req", k), int'(O_Commit_Req), 0);
      check($sformatf("wrapA%0d.num", k), int'(O_Num), 16);
      tick();
      pend = q.pop_front();
      check($sformatf("wrapB%0d.req", k), int'(O_Commit_Req), 1);
      check($sformatf("wrapB%0d.no", k), int'(O_Commit_No), pend);
      check($sformatf("wrapB%0d.num", k), int'(O_Num), 15);
    end

    // Flush with one non-head entry already done
    do_reset();
    issue(4);
    issue(8);
    issue(12);
    issue(6);
    I_Done_S_Req = 1'b1;
    I_Done_S_No  = W'(8);
    tick();
    idle();
    check_out("fl.pre", 0, 0, 4, 0, 0, 0, 0);
    I_Flush = 1'b1;
    tick();
    check_out("fl0", 0, 0, 4, 0, 0, 1, 0);
    I_Issue_Req = 1'b1;
    I_Issue_No  = W'(3);
    tick();
    idle();
    check_out("fl1", 1, 4, 3, 0, 0, 1, 1);
    tick();
    check_out("fl2", 1, 8, 2, 0, 0, 1, 1);
    tick();
    check_out("fl3", 1, 12, 1, 0, 0, 1, 1);
    tick();
    check_out("fl4", 1, 6, 0, 0, 1, 0, 1);
    tick();
    check_out("fl5", 0, 0, 0, 0, 1, 0, 1);
    issue(8);
    check_out("fl.re", 0, 0, 1, 0, 0, 0, 1);
    tick();
    check_out("fl.nodone", 0, 0, 1, 0, 0, 0, 1);

    // Reset in the middle of a flush
    do_reset();
    issue(1);
    issue(2);
    issue(3);
    I_Flush = 1'b1;
    tick();
    idle();
    check_out("rf0", 0, 0, 3, 0, 0, 1, 0);
    tick();
    check_out("rf1", 1, 1, 2, 0, 0, 1, 0);
    reset = 1'b0;
    tick();
    check_out("rf2", 0, 0, 0, 0, 1, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("rf.post%0d", i), 0, 0, 0, 0, 1, 0, 0);
    end

    // Completion for a number that is not outstanding
    I_Done_V_Req = 1'b1;
    I_Done_V_No  = W'(7);
    tick();
    idle();
    check_out("bad.done", 0, 0, 0, 0, 1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
